// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in, serial-out transmitter.
// Bit-order constants are the legal values of the LSB_FIRST parameter.
package piso_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  localparam int MSB_FIRST = 0;
  localparam int LSB_FIRST = 1;

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out handshake bundle between a word producer and the serializer.
// The master side supplies words; the slave side is the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = piso_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sout_last, busy
  );

endinterface

// File: rtl/piso_serializer_shift_reg.sv
// Loadable shift register that moves its contents toward the selected output end,
// back-filling with zeros. Clear beats load, load beats shift.
module piso_shift_reg #(
  parameter int WIDTH     = piso_pkg::DEFAULT_WIDTH,
  parameter int LSB_FIRST = piso_pkg::MSB_FIRST
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             out_bit
);

  localparam bit LSB_MODE = (LSB_FIRST == piso_pkg::LSB_FIRST);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift_en) begin
      if (LSB_MODE) begin
        sreg <= {1'b0, sreg[WIDTH-1:1]};
      end else begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign out_bit = LSB_MODE ? sreg[0] : sreg[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Serializes WIDTH-bit words onto a single wire, one bit per clock, with frame strobes.
// A word may be accepted on the last bit of the previous one so frames stream gaplessly.
module piso_serializer #(
  parameter int WIDTH     = piso_pkg::DEFAULT_WIDTH,
  parameter int LSB_FIRST = piso_pkg::MSB_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  piso_serializer_if.slave  bus
);

  import piso_pkg::*;

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             at_last;
  logic             accept;
  logic             tx_bit;

  assign at_last       = (state == SHIFT) && (bit_cnt == LAST_CNT);
  assign bus.din_ready = rst && ((state == IDLE) || at_last);
  assign accept        = bus.din_valid && bus.din_ready;

  // On the final bit a fresh accept restarts the count in place instead of idling.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (at_last) begin
            bit_cnt <= '0;
            if (!accept) begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift_reg (
    .clk      (clk),
    .clr_n    (rst),
    .load     (accept),
    .shift_en (state == SHIFT),
    .din      (bus.din),
    .out_bit  (tx_bit)
  );

  assign bus.sout       = (state == SHIFT) && tx_bit;
  assign bus.sout_valid = (state == SHIFT);
  assign bus.sout_last  = at_last;
  assign bus.busy       = (state == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Drives one word stream into an MSB-first and an LSB-first serializer side by side
// and compares both against a queue-of-bits model every cycle.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic [W-1:0] din       = '0;
  logic         din_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Bits still owed on the wire, front element is the one on sout this cycle.
  bit q_msb[$];
  bit q_lsb[$];

  logic [31:0] cap_m, cap_l, cap_last, cap_model, ready_log;
  int          cap_n, cap_model_n;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus_msb ();
  piso_serializer_if #(.WIDTH(W)) bus_lsb ();

  assign bus_msb.din       = din;
  assign bus_msb.din_valid = din_valid;
  assign bus_lsb.din       = din;
  assign bus_lsb.din_valid = din_valid;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_msb)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_lsb)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [W-1:0] d, input logic v);
    rst       = r;
    din       = d;
    din_valid = v;
    #2;
    ready_log = {ready_log[30:0], bus_msb.din_ready};
    @(posedge clk);
    #1;
  endtask

  task automatic clearCapture();
    cap_m       = '0;
    cap_l       = '0;
    cap_last    = '0;
    cap_model   = '0;
    ready_log   = '0;
    cap_n       = 0;
    cap_model_n = 0;
  endtask

  // Model: a word taken while at most one bit is still owed appends its bits in wire order.
  always @(posedge clk) begin
    bit take;
    take = rst && din_valid && (q_msb.size() <= 1);
    if (!rst) begin
      q_msb.delete();
      q_lsb.delete();
    end else begin
      if (q_msb.size() > 0) begin
        q_msb.delete(0);
        q_lsb.delete(0);
      end
      if (take) begin
        for (int i = 0; i < W; i++) begin
          q_msb.push_back(din[W-1-i]);
          q_lsb.push_back(din[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_v, exp_l, exp_r, exp_m, exp_ls;
    exp_v  = (q_msb.size() > 0);
    exp_l  = (q_msb.size() == 1);
    exp_r  = rst && (q_msb.size() <= 1);
    exp_m  = exp_v ? q_msb[0] : 1'b0;
    exp_ls = exp_v ? q_lsb[0] : 1'b0;
    if (check_en) begin
      checkOutput("msb_ready", 32'(bus_msb.din_ready),  32'(exp_r));
      checkOutput("msb_valid", 32'(bus_msb.sout_valid), 32'(exp_v));
      checkOutput("msb_last",  32'(bus_msb.sout_last),  32'(exp_l));
      checkOutput("msb_busy",  32'(bus_msb.busy),       32'(exp_v));
      checkOutput("msb_sout",  32'(bus_msb.sout),       32'(exp_m));
      checkOutput("lsb_ready", 32'(bus_lsb.din_ready),  32'(exp_r));
      checkOutput("lsb_valid", 32'(bus_lsb.sout_valid), 32'(exp_v));
      checkOutput("lsb_last",  32'(bus_lsb.sout_last),  32'(exp_l));
      checkOutput("lsb_busy",  32'(bus_lsb.busy),       32'(exp_v));
      checkOutput("lsb_sout",  32'(bus_lsb.sout),       32'(exp_ls));
    end
    if (bus_msb.sout_valid === 1'b1) begin
      cap_m    = {cap_m[30:0], bus_msb.sout};
      cap_last = {cap_last[30:0], bus_msb.sout_last};
      cap_n++;
    end
    if (bus_lsb.sout_valid === 1'b1) begin
      cap_l = {cap_l[30:0], bus_lsb.sout};
    end
    if (exp_v) begin
      cap_model = {cap_model[30:0], exp_m};
      cap_model_n++;
    end
  end

  initial begin
    clearCapture();

    // Reset held for three edges, then released.
    applyStimulus(1'b0, '0, 1'b0);
    check_en = 1'b1;
    repeat (2) applyStimulus(1'b0, '0, 1'b0);
    clearCapture();
    applyStimulus(1'b1, '0, 1'b0);
    checkOutput("rst_release_ready", 32'(ready_log[0]), 32'd1);
    checkOutput("rst_valid", 32'(bus_msb.sout_valid), 32'd0);
    checkOutput("rst_busy",  32'(bus_msb.busy),       32'd0);

    // Single word, pulsed valid.
    clearCapture();
    applyStimulus(1'b1, 4'b1011, 1'b1);
    repeat (5) applyStimulus(1'b1, '0, 1'b0);
    checkOutput("single_count",     32'(cap_n),        32'd4);
    checkOutput("single_msb",       32'(cap_m[3:0]),   32'hB);
    checkOutput("single_lsb",       32'(cap_l[3:0]),   32'hD);
    checkOutput("single_last",      32'(cap_last[3:0]), 32'h1);
    checkOutput("single_model",     32'(cap_model[3:0]), 32'hB);
    checkOutput("single_model_cnt", 32'(cap_model_n),  32'd4);

    // Back-to-back words with valid held high.
    clearCapture();
    applyStimulus(1'b1, 4'hA, 1'b1);
    repeat (7) applyStimulus(1'b1, 4'h5, 1'b1);
    applyStimulus(1'b1, 4'h5, 1'b0);
    repeat (2) applyStimulus(1'b1, '0, 1'b0);
    checkOutput("b2b_count", 32'(cap_n),           32'd8);
    checkOutput("b2b_msb",   32'(cap_m[7:0]),      32'hA5);
    checkOutput("b2b_lsb",   32'(cap_l[7:0]),      32'h5A);
    checkOutput("b2b_last",  32'(cap_last[7:0]),   32'h11);
    checkOutput("b2b_model", 32'(cap_model[7:0]),  32'hA5);
    checkOutput("b2b_ready", 32'(ready_log[10:0]), 32'b100_0100_0111);

    // New word offered while busy is ignored until the last bit.
    clearCapture();
    applyStimulus(1'b1, 4'h3, 1'b1);
    repeat (4) applyStimulus(1'b1, 4'hF, 1'b1);
    repeat (5) applyStimulus(1'b1, '0, 1'b0);
    checkOutput("busy_count", 32'(cap_n),          32'd8);
    checkOutput("busy_msb",   32'(cap_m[7:0]),     32'h3F);
    checkOutput("busy_lsb",   32'(cap_l[7:0]),     32'hCF);
    checkOutput("busy_ready", 32'(ready_log[9:0]), 32'b10_0010_0011);

    // Reset and accept on the same edge: reset wins.
    clearCapture();
    applyStimulus(1'b0, 4'h6, 1'b1);
    repeat (3) applyStimulus(1'b1, '0, 1'b0);
    checkOutput("rst_accept_count", 32'(cap_n),          32'd0);
    checkOutput("rst_accept_ready", 32'(ready_log[3:0]), 32'b0111);

    // Reset in the middle of a word, then a clean word.
    applyStimulus(1'b1, 4'hC, 1'b1);
    applyStimulus(1'b1, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("midrst_msb_valid", 32'(bus_msb.sout_valid), 32'd0);
    checkOutput("midrst_msb_busy",  32'(bus_msb.busy),       32'd0);
    checkOutput("midrst_lsb_valid", 32'(bus_lsb.sout_valid), 32'd0);
    clearCapture();
    applyStimulus(1'b1, 4'h9, 1'b1);
    repeat (5) applyStimulus(1'b1, '0, 1'b0);
    checkOutput("after_rst_count", 32'(cap_n),         32'd4);
    checkOutput("after_rst_msb",   32'(cap_m[3:0]),    32'h9);
    checkOutput("after_rst_lsb",   32'(cap_l[3:0]),    32'h9);
    checkOutput("after_rst_last",  32'(cap_last[3:0]), 32'h1);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
